// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester command channels, the two
// response channels and the shared-ALU connection of alu_arbiter.
//   slave  : seen by the arbiter (takes commands, returns results, drives ALU)
//   master : seen by the environment (requesters and the ALU datapath)
// Signals:
//   reqN_valid/ready, reqN_a, reqN_b (4b), reqN_op (3b)  command channel N
//   rspN_valid/ready, rspN_data (4b)                     response channel N
//   alu_a, alu_b (4b), alu_op (3b), alu_res (4b)         shared ALU
interface alu_arbiter_if;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready, rsp1_ready;
  logic [3:0] rsp0_data, rsp1_data;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_res;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, rsp0_ready, rsp1_ready, alu_res,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_data, rsp1_data, alu_a, alu_b, alu_op
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, rsp0_ready, rsp1_ready, alu_res,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_data, rsp1_data, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 4-bit ALU between two requesters.
// A command is accepted in IDLE, its operands drive the ALU for one cycle,
// the ALU result is captured and then returned on the owner's response
// channel, held until the owner takes it.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       alu_arbiter_if.slave (command, response and ALU signals)
//   done_cnt  completed response handshakes, wraps at 256
//   busy      high whenever a transaction is in flight
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate between requesters, ALU inputs held at zero
// EXEC  | latched operands on the ALU, result captured at cycle end
// RESP  | result offered to the owner until its rsp_ready
module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic [7:0]   done_cnt,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q;
  logic       owner_q;
  logic [3:0] a_q, b_q, res_q;
  logic [2:0] op_q;
  logic [7:0] done_q;
  logic       grant0, grant1;
  logic       accept, rsp_hs;

  // Under contention the requester that did not win last time goes first.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

  // Every output is forced low while rst is high so that no handshake can
  // complete during the reset cycle, whatever state is being cleared.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    rsp_hs         = 1'b0;
    busy           = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp0_data  = 4'd0;
    bus.rsp1_data  = 4'd0;
    bus.alu_a      = 4'd0;
    bus.alu_b      = 4'd0;
    bus.alu_op     = 3'd0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          bus.req0_ready = grant0;
          bus.req1_ready = grant1;
          accept         = grant0 || grant1;
          if (accept) state_d = EXEC;
        end
        EXEC: begin
          busy       = 1'b1;
          bus.alu_a  = a_q;
          bus.alu_b  = b_q;
          bus.alu_op = op_q;
          state_d    = RESP;
        end
        RESP: begin
          busy       = 1'b1;
          bus.alu_a  = a_q;
          bus.alu_b  = b_q;
          bus.alu_op = op_q;
          if (owner_q) begin
            bus.rsp1_valid = 1'b1;
            bus.rsp1_data  = res_q;
            rsp_hs         = bus.rsp1_ready;
          end else begin
            bus.rsp0_valid = 1'b1;
            bus.rsp0_data  = res_q;
            rsp_hs         = bus.rsp0_ready;
          end
          if (rsp_hs) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      op_q         <= 3'd0;
      res_q        <= 4'd0;
      done_q       <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= grant1;
        last_grant_q <= grant1;
        a_q          <= grant1 ? bus.req1_a  : bus.req0_a;
        b_q          <= grant1 ? bus.req1_b  : bus.req0_b;
        op_q         <= grant1 ? bus.req1_op : bus.req0_op;
      end
      if (state_q == EXEC) res_q <= bus.alu_res;
      if (rsp_hs) done_q <= done_q + 8'd1;
    end
  end

  assign done_cnt = done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if bus();
  logic [7:0] done_cnt;
  logic       busy;

  logic [1:0]      req_valid, rsp_ready;
  logic [1:0][3:0] req_a, req_b;
  logic [1:0][2:0] req_op;
  logic [1:0]      req_ready, rsp_valid;
  logic [1:0][3:0] rsp_data;

  assign bus.req0_valid = req_valid[0];
  assign bus.req1_valid = req_valid[1];
  assign bus.req0_a     = req_a[0];
  assign bus.req0_b     = req_b[0];
  assign bus.req1_a     = req_a[1];
  assign bus.req1_b     = req_b[1];
  assign bus.req0_op    = req_op[0];
  assign bus.req1_op    = req_op[1];
  assign bus.rsp0_ready = rsp_ready[0];
  assign bus.rsp1_ready = rsp_ready[1];
  assign req_ready      = {bus.req1_ready, bus.req0_ready};
  assign rsp_valid      = {bus.rsp1_valid, bus.rsp0_valid};
  assign rsp_data       = {bus.rsp1_data, bus.rsp0_data};

  // The shared ALU the arbiter drives; compare (op 110) means a < b.
  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return (a < b) ? 4'd1 : 4'd0;
      default: return (a == b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign bus.alu_res = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

  alu_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .done_cnt (done_cnt),
    .busy     (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    int         stall;
    logic [3:0] res;
  } vec_t;

  vec_t tbl[10];

  // One isolated transaction from requester id, with `stall` cycles of
  // rsp_ready low at the start of the response.
  task automatic do_txn(input vec_t v);
    int o;
    logic [1:0] one;
    o   = 1 - v.id;
    one = 2'b01 << v.id;
    @(posedge clk); #1;
    req_valid[v.id] = 1'b1;
    req_a[v.id] = v.a; req_b[v.id] = v.b; req_op[v.id] = v.op;
    @(negedge clk);
    chk("accept_ready", req_ready, one);
    chk("accept_busy", busy, 1'b0);
    @(posedge clk); #1;
    req_valid[v.id] = 1'b0;
    req_a[v.id] = ~v.a; req_b[v.id] = ~v.b; req_op[v.id] = ~v.op;
    rsp_ready = 2'b00;
    rsp_ready[v.id] = (v.stall == 0);
    @(negedge clk);
    chk("exec_busy", busy, 1'b1);
    chk("exec_alu_a", bus.alu_a, v.a);
    chk("exec_alu_b", bus.alu_b, v.b);
    chk("exec_alu_op", bus.alu_op, v.op);
    chk("exec_rsp_valid", rsp_valid, 2'b00);
    for (int k = 0; k <= v.stall; k++) begin
      @(posedge clk); #1;
      if (k == v.stall) rsp_ready[v.id] = 1'b1;
      @(negedge clk);
      chk("resp_valid", rsp_valid, one);
      chk("resp_data", rsp_data[v.id], v.res);
      chk("resp_other_data", rsp_data[o], 4'd0);
      chk("resp_ready_low", req_ready, 2'b00);
      chk("resp_done_hold", done_cnt, exp_done[7:0]);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    exp_done = (exp_done + 1) % 256;
    @(negedge clk);
    chk("post_done", done_cnt, exp_done[7:0]);
    chk("post_busy", busy, 1'b0);
    chk("post_rsp_valid", rsp_valid, 2'b00);
  endtask

  // behavioural model state for the random phase
  bit         m_busy;
  int         m_age, m_owner, m_last, m_done, win;
  logic [3:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  logic [1:0] acc, e_ready, e_rv;
  logic [1:0][3:0] e_rd;

  initial begin
    tbl[0] = '{0, 4'd3,  4'd4,  3'd0, 0, 4'd7};
    tbl[1] = '{1, 4'd2,  4'd5,  3'd1, 3, 4'b1101};
    tbl[2] = '{0, 4'd7,  4'd7,  3'd7, 0, 4'b0001};
    tbl[3] = '{0, 4'd7,  4'd8,  3'd7, 0, 4'b0000};
    tbl[4] = '{1, 4'd9,  4'd0,  3'd2, 1, 4'd6};
    tbl[5] = '{0, 4'd12, 4'd10, 3'd4, 2, 4'd14};
    tbl[6] = '{1, 4'd15, 4'd1,  3'd0, 0, 4'd0};
    tbl[7] = '{0, 4'd3,  4'd9,  3'd6, 0, 4'd1};
    tbl[8] = '{1, 4'd6,  4'd3,  3'd3, 0, 4'd2};
    tbl[9] = '{0, 4'd9,  4'd3,  3'd5, 0, 4'd10};

    // reset with both requesters pushing: nothing may be accepted
    rst = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a = '0; req_b = '0; req_op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_op}, 11'd0);
    chk("rst_done", done_cnt, 8'd0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;

    for (int i = 0; i < 10; i++) do_txn(tbl[i]);

    // reset while requester 0's result is being offered
    @(posedge clk); #1;
    req_valid = 2'b01; req_a[0] = 4'd5; req_b[0] = 4'd1; req_op[0] = 3'd0;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("rr_accept", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_rsp_before", rsp_valid, 2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // continuous contention straight out of reset
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a[0] = 4'd6; req_b[0] = 4'd3; req_op[0] = 3'd3;
    req_a[1] = 4'd5; req_b[1] = 4'd3; req_op[1] = 3'd5;
    for (int c = 0; c < 12; c++) begin
      logic [1:0] who, er, ev;
      who = (((c / 3) % 2) == 0) ? 2'b01 : 2'b10;
      er  = ((c % 3) == 0) ? who : 2'b00;
      ev  = ((c % 3) == 2) ? who : 2'b00;
      @(negedge clk);
      chk("ct_ready", req_ready, er);
      chk("ct_rsp_valid", rsp_valid, ev);
      chk("ct_data0", rsp_data[0], ev[0] ? 4'd2 : 4'd0);
      chk("ct_data1", rsp_data[1], ev[1] ? 4'd6 : 4'd0);
      chk("ct_done", done_cnt, c / 3);
      chk("ct_busy", busy, (c % 3) != 0);
    end
    req_valid = 2'b00;

    // 256 back-to-back transactions wrap done_cnt
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b01; rsp_ready = 2'b11;
    req_a[0] = 4'd1; req_b[0] = 4'd1; req_op[0] = 3'd0;
    for (int c = 0; c <= 768; c++) begin
      @(negedge clk);
      chk("wrap_done", done_cnt, (c / 3) % 256);
    end

    // randomized traffic against the transaction-level model
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_busy = 0; m_age = 0; m_owner = 0; m_last = 1; m_done = 0;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; acc = 2'b00; win = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(req_valid[i] && !acc[i])) req_valid[i] = ($urandom_range(0, 2) != 0);
        req_a[i]  = 4'($urandom_range(0, 15));
        req_b[i]  = 4'($urandom_range(0, 15));
        req_op[i] = 3'($urandom_range(0, 7));
      end
      rsp_ready = 2'($urandom_range(0, 3));
      @(negedge clk);
      e_ready = 2'b00; e_rv = 2'b00; e_rd = '0;
      if (!m_busy) begin
        win = (req_valid == 2'b11) ? 1 - m_last : int'(req_valid[1]);
        if (req_valid != 2'b00) e_ready[win] = 1'b1;
      end else if (m_age > 0) begin
        e_rv[m_owner] = 1'b1;
        e_rd[m_owner] = m_res;
      end
      chk("rnd_ready", req_ready, e_ready);
      chk("rnd_rsp_valid", rsp_valid, e_rv);
      chk("rnd_rsp_data", rsp_data, e_rd);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_done", done_cnt, m_done);
      chk("rnd_alu", {bus.alu_a, bus.alu_b, bus.alu_op},
          m_busy ? {m_a, m_b, m_op} : 11'd0);
      acc = e_ready & req_valid;
      if (!m_busy) begin
        if (acc != 2'b00) begin
          m_busy = 1; m_age = 0; m_owner = win; m_last = win;
          m_a = req_a[win]; m_b = req_b[win]; m_op = req_op[win];
          m_res = alu_fn(m_a, m_b, m_op);
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (rsp_ready[m_owner]) begin
        m_busy = 0;
        m_done = (m_done + 1) % 256;
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
